// File: rtl/debounce_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_multi_if
//  Purpose  : Signal bundle between raw board inputs and the multi-channel
//             debouncer. It carries the raw pins in, the debounced levels and
//             edge pulses out, and the optional sticky change-status flags.
//  Modports : slave  - the debouncer. It takes din and sts_clr and drives the
//                      rest.
//             master - the consumer or driver side. It drives din and
//                      sts_clr and observes the rest.
//  Signals  : din       [CH_NUM]  raw asynchronous inputs
//             db_out    [CH_NUM]  debounced level
//             rise_pls  [CH_NUM]  one-cycle pulse when db_out goes 0->1
//             fall_pls  [CH_NUM]  one-cycle pulse when db_out goes 1->0
//             any_chg   [1]       OR of every rise/fall pulse
//             sts_clr   [CH_NUM]  write-1-to-clear for chg_sts
//             chg_sts   [CH_NUM]  sticky change flags
//  Revision : 1.0  initial release
// ============================================================================
interface debounce_multi_if #(
  parameter int CH_NUM = 8
);

  logic [CH_NUM-1:0] din;
  logic [CH_NUM-1:0] db_out;
  logic [CH_NUM-1:0] rise_pls;
  logic [CH_NUM-1:0] fall_pls;
  logic              any_chg;
  logic [CH_NUM-1:0] sts_clr;
  logic [CH_NUM-1:0] chg_sts;

  modport slave (
    input  din,
    input  sts_clr,
    output db_out,
    output rise_pls,
    output fall_pls,
    output any_chg,
    output chg_sts
  );

  modport master (
    output din,
    output sts_clr,
    input  db_out,
    input  rise_pls,
    input  fall_pls,
    input  any_chg,
    input  chg_sts
  );

endinterface
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_multi
//  Purpose  : Debouncer for slow board signals such as PRSNT#, buttons and
//             alerts, running on clk_1k. It has CH_NUM independent channels.
//             Each channel has a 2-flop synchroniser and separate rise and
//             fall filter depths. It also produces registered one-cycle edge
//             pulses.
//  Ports    : clk_1k      in   1 kHz free-running clock
//             cpld_rst_n  in   asynchronous active-low reset. Deassertion is
//                              synchronised externally.
//             bus         slave modport of debounce_multi_if. It carries din
//                         and sts_clr in, and db_out, rise_pls, fall_pls,
//                         any_chg and chg_sts out.
//  Params   : CH_NUM   number of channels (1..32)
//             DB_RISE  consecutive samples at 1 needed for db_out 0->1 (>=1)
//             DB_FALL  consecutive samples at 0 needed for db_out 1->0 (>=1)
//             RST_VAL  reset level of the synchroniser and db_out per channel
//  Config   : DEBOUNCE_STATUS_LATCH_EN
//             When defined, this builds the sticky chg_sts flags with
//             write-1-to-clear. When undefined, chg_sts is tied to zero and
//             sts_clr is ignored.
//  Latency  : When a din step is held stable, db_out follows 2+N clk_1k edges
//             later. N is DB_RISE or DB_FALL, depending on the new level.
//  Revision : 1.0  initial release
// ============================================================================
module debounce_multi #(
  parameter int               CH_NUM  = 8,
  parameter int               DB_RISE = 3,
  parameter int               DB_FALL = 1,
  parameter logic [CH_NUM-1:0] RST_VAL = {CH_NUM{1'b1}}
) (
  input  logic            clk_1k,
  input  logic            cpld_rst_n,
  debounce_multi_if.slave bus
);

  // --------------------------------------------------------------------------
  // Build-time parameter checks
  // --------------------------------------------------------------------------
  if (DB_RISE < 1) begin : g_chk_db_rise
    $error("debounce_multi: DB_RISE must be >= 1");
  end

  if (DB_FALL < 1) begin : g_chk_db_fall
    $error("debounce_multi: DB_FALL must be >= 1");
  end

  if ((CH_NUM < 1) || (CH_NUM > 32)) begin : g_chk_ch_num
    $error("debounce_multi: CH_NUM must be in 1..32");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_DB_MAX = (DB_RISE > DB_FALL) ? DB_RISE : DB_FALL;
  localparam int c_CNT_W  = $clog2(c_DB_MAX + 1);

  // The last count value before the output flips is N-1. The counter never
  // goes past it.
  localparam logic [c_CNT_W-1:0] c_RISE_LAST = c_CNT_W'(DB_RISE - 1);
  localparam logic [c_CNT_W-1:0] c_FALL_LAST = c_CNT_W'(DB_FALL - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CH_NUM-1:0]  r_s1;
  logic [CH_NUM-1:0]  r_s2;
  logic [CH_NUM-1:0]  r_db;
  logic [CH_NUM-1:0]  r_rise;
  logic [CH_NUM-1:0]  r_fall;
  logic [c_CNT_W-1:0] r_cnt [CH_NUM];

  logic [CH_NUM-1:0]  w_db_nxt;
  logic [CH_NUM-1:0]  w_rise_nxt;
  logic [CH_NUM-1:0]  w_fall_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt [CH_NUM];

  // --------------------------------------------------------------------------
  // Per-channel filter next state
  // A channel counts only while the synchronised sample disagrees with the
  // current debounced level. Any agreeing sample restarts the window. This
  // means a glitch shorter than N samples never reaches db_out. The depth N
  // is chosen by the candidate new level: a sample of 1 uses DB_RISE and a
  // sample of 0 uses DB_FALL. Because the candidate is always ~db_out while
  // counting, N cannot change mid-window.
  // --------------------------------------------------------------------------
  always_comb begin
    w_db_nxt   = r_db;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] == (r_s2[i] ? c_RISE_LAST : c_FALL_LAST)) begin
          w_db_nxt[i]   = r_s2[i];
          w_rise_nxt[i] = r_s2[i];
          w_fall_nxt[i] = ~r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + c_CNT_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // The synchroniser resets to RST_VAL rather than 0. Otherwise, with the pin
  // idle at the reset level, it would present a false change right after
  // reset. The edge pulses are registered together with db_out, so each pulse
  // is high in exactly the cycle where db_out first shows the new level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
    if (!cpld_rst_n) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_db   <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1   <= bus.din;
      r_s2   <= r_s1;
      r_db   <= w_db_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      for (int i = 0; i < CH_NUM; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.db_out   = r_db;
  assign bus.rise_pls = r_rise;
  assign bus.fall_pls = r_fall;
  assign bus.any_chg  = |(r_rise | r_fall);

  // --------------------------------------------------------------------------
  // Sticky change status
  // A new edge pulse takes priority over a coincident clear. This way, a
  // change that lands in the same cycle as software acknowledging the
  // previous one is not lost.
  // --------------------------------------------------------------------------
`ifdef DEBOUNCE_STATUS_LATCH_EN
  logic [CH_NUM-1:0] r_chg_sts;

  always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
    if (!cpld_rst_n) begin
      r_chg_sts <= '0;
    end else begin
      r_chg_sts <= (r_chg_sts & ~bus.sts_clr) | r_rise | r_fall;
    end
  end

  assign bus.chg_sts = r_chg_sts;
`else
  logic [CH_NUM-1:0] w_unused_sts_clr;

  assign w_unused_sts_clr = bus.sts_clr;
  assign bus.chg_sts      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_multi
//  Purpose  : Self-checking bench for debounce_multi. It is configured with
//             CH_NUM=8, DB_RISE=3, DB_FALL=1 and RST_VAL=8'hFF. Each
//             scoreboard entry holds two things: the inputs to apply before a
//             clock edge, and the outputs the debouncer must show after that
//             edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_debounce_multi;

  localparam int CH = 8;
`ifdef DEBOUNCE_STATUS_LATCH_EN
  localparam bit STS_EN = 1'b1;
`else
  localparam bit STS_EN = 1'b0;
`endif

  logic clk_1k = 1'b0;
  logic cpld_rst_n;

  always #5 clk_1k = ~clk_1k;

  debounce_multi_if #(.CH_NUM(CH)) bus ();

  debounce_multi #(
    .CH_NUM  (CH),
    .DB_RISE (3),
    .DB_FALL (1),
    .RST_VAL (8'hFF)
  ) dut (
    .clk_1k     (clk_1k),
    .cpld_rst_n (cpld_rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] clr;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] sts;
    bit         chk_sts;
    string      tag;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Queue one cycle: the inputs applied before the edge and the outputs
  // required after it. Without the status latch, chg_sts must stay 0.
  task automatic push(input logic [7:0] din, input logic [7:0] clr,
                      input logic [7:0] db, input logic [7:0] rise,
                      input logic [7:0] fall, input logic [7:0] sts,
                      input bit chk_sts, input string tag);
    ent_t e;
    e.din     = din;
    e.clr     = clr;
    e.db      = db;
    e.rise    = rise;
    e.fall    = fall;
    e.sts     = STS_EN ? sts : 8'h00;
    e.chk_sts = chk_sts;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  task automatic p(input logic [7:0] din, input logic [7:0] db,
                   input logic [7:0] rise, input logic [7:0] fall,
                   input string tag);
    push(din, 8'h00, db, rise, fall, 8'h00, 1'b0, tag);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    ent_t e;
    bus.din     = 8'hFF;
    bus.sts_clr = 8'h00;
    cpld_rst_n  = 1'b1;
    #2 cpld_rst_n = 1'b0;
    repeat (3) @(posedge clk_1k);
    #1;
    n_checks++;
    if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, bus.chg_sts} !==
        {8'hFF, 8'h00, 8'h00, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL in_reset: db/rise/fall/chg/sts got %h/%h/%h/%b/%h need ff/00/00/0/00",
               bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, bus.chg_sts);
    end
    cpld_rst_n = 1'b1;
    repeat (10) push(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, "post_reset_idle");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
      if (e.chk_sts) begin
        n_checks++;
        if (bus.chg_sts !== e.sts) begin
          n_fail++;
          $display("FAIL %s_sts t=%0t: chg_sts got %h need %h", e.tag, $time, bus.chg_sts, e.sts);
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // ch0 falls with DB_FALL=1. db_out changes on the 3rd edge, with a single
  // fall pulse.
  task automatic test_fall();
    ent_t e;
    p(8'hFE, 8'hFF, 8'h00, 8'h00, "fall_e1");
    p(8'hFE, 8'hFF, 8'h00, 8'h00, "fall_e2");
    p(8'hFE, 8'hFE, 8'h00, 8'h01, "fall_e3");
    p(8'hFE, 8'hFE, 8'h00, 8'h00, "fall_e4");
    p(8'hFE, 8'hFE, 8'h00, 8'h00, "fall_e5");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // ch1 rises with DB_RISE=3. db_out changes on the 5th edge. A 2-sample high
  // glitch is filtered out. A 3-sample high pulse is just long enough to get
  // through, and then falls again one edge later.
  task automatic test_rise_glitch();
    ent_t e;
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "pre_fall_ch1");
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "pre_fall_ch1");
    p(8'hFC, 8'hFC, 8'h00, 8'h02, "pre_fall_ch1_pls");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "pre_fall_ch1");
    repeat (4) p(8'hFE, 8'hFC, 8'h00, 8'h00, "rise_wait");
    p(8'hFE, 8'hFE, 8'h02, 8'h00, "rise_e5");
    p(8'hFE, 8'hFE, 8'h00, 8'h00, "rise_e6");
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "refall");
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "refall");
    p(8'hFC, 8'hFC, 8'h00, 8'h02, "refall_pls");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "refall");
    repeat (2) p(8'hFE, 8'hFC, 8'h00, 8'h00, "glitch2");
    repeat (6) p(8'hFC, 8'hFC, 8'h00, 8'h00, "glitch2_hold");
    repeat (3) p(8'hFE, 8'hFC, 8'h00, 8'h00, "pulse3");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "pulse3");
    p(8'hFC, 8'hFE, 8'h02, 8'h00, "pulse3_rise");
    p(8'hFC, 8'hFC, 8'h00, 8'h02, "pulse3_fall");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "pulse3_end");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // din[7:4] toggle together. All four channels must change and pulse in the
  // same cycle, first falling and then rising back.
  task automatic test_back_to_back();
    ent_t e;
    p(8'h0C, 8'hFC, 8'h00, 8'h00, "multi_fall");
    p(8'h0C, 8'hFC, 8'h00, 8'h00, "multi_fall");
    p(8'h0C, 8'h0C, 8'h00, 8'hF0, "multi_fall_pls");
    p(8'h0C, 8'h0C, 8'h00, 8'h00, "multi_fall");
    repeat (4) p(8'hFC, 8'h0C, 8'h00, 8'h00, "multi_rise_wait");
    p(8'hFC, 8'hFC, 8'hF0, 8'h00, "multi_rise_pls");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "multi_rise");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Reset lands while ch1 is two samples into a rise window. db_out must
  // return to RST_VAL immediately. After release, filtering restarts cleanly:
  // a later rise still needs the full 5 edges.
  task automatic test_reset_mid();
    ent_t e;
    repeat (4) p(8'hFE, 8'hFC, 8'h00, 8'h00, "mid_window");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
    end
    cpld_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: db/rise/fall/chg got %h/%h/%h/%b need ff/00/00/0",
               bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg);
    end
    bus.din = 8'h00;
    @(posedge clk_1k); #1;
    n_checks++;
    if (bus.db_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL rst_hold: db got %h need ff", bus.db_out);
    end
    cpld_rst_n = 1'b1;
    p(8'hFE, 8'hFF, 8'h00, 8'h00, "rel");
    p(8'hFE, 8'hFF, 8'h00, 8'h00, "rel");
    p(8'hFE, 8'hFE, 8'h00, 8'h01, "rel_fall0");
    repeat (4) p(8'hFE, 8'hFE, 8'h00, 8'h00, "rel_ch1_quiet");
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "rel_fall1");
    p(8'hFC, 8'hFE, 8'h00, 8'h00, "rel_fall1");
    p(8'hFC, 8'hFC, 8'h00, 8'h02, "rel_fall1_pls");
    p(8'hFC, 8'hFC, 8'h00, 8'h00, "rel_fall1");
    repeat (4) p(8'hFE, 8'hFC, 8'h00, 8'h00, "rel_rise_wait");
    p(8'hFE, 8'hFE, 8'h02, 8'h00, "rel_rise_pls");
    p(8'hFE, 8'hFE, 8'h00, 8'h00, "rel_rise");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Sticky status on ch2. An edge sets the flag. A clear that coincides with
  // a new edge pulse leaves it set. A lone clear drops it. Without the latch,
  // every expectation is 0.
  task automatic test_status();
    ent_t e;
    push(8'hFE, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b1, "sts_clr_all");
    push(8'hFA, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b1, "sts_fall");
    push(8'hFA, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b1, "sts_fall");
    push(8'hFA, 8'h00, 8'hFA, 8'h00, 8'h04, 8'h00, 1'b1, "sts_fall_pls");
    push(8'hFA, 8'h00, 8'hFA, 8'h00, 8'h00, 8'h04, 1'b1, "sts_set");
    repeat (4) push(8'hFE, 8'h00, 8'hFA, 8'h00, 8'h00, 8'h04, 1'b1, "sts_hold");
    push(8'hFE, 8'h00, 8'hFE, 8'h04, 8'h00, 8'h04, 1'b1, "sts_rise_pls");
    push(8'hFE, 8'h04, 8'hFE, 8'h00, 8'h00, 8'h04, 1'b1, "sts_set_wins");
    push(8'hFE, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h04, 1'b1, "sts_kept");
    push(8'hFE, 8'h04, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b1, "sts_lone_clr");
    push(8'hFE, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b1, "sts_cleared");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.din = e.din; bus.sts_clr = e.clr;
      @(posedge clk_1k); #1;
      n_checks++;
      if ({bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg} !==
          {e.db, e.rise, e.fall, |(e.rise | e.fall)}) begin
        n_fail++;
        $display("FAIL %s t=%0t: db/rise/fall/chg got %h/%h/%h/%b need %h/%h/%h/%b", e.tag, $time,
                 bus.db_out, bus.rise_pls, bus.fall_pls, bus.any_chg, e.db, e.rise, e.fall, |(e.rise | e.fall));
      end
      if (e.chk_sts) begin
        n_checks++;
        if (bus.chg_sts !== e.sts) begin
          n_fail++;
          $display("FAIL %s t=%0t: chg_sts got %h need %h", e.tag, $time, bus.chg_sts, e.sts);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_rise_glitch();
    test_back_to_back();
    test_reset_mid();
    test_status();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
